// File: rtl/fptd_epsilon_pipe_lanes_pkg.sv
// Shared constants and types for the FPTD max-log epsilon unit.
// EPS_PAIR[g][p] = {alpha state, beta state} for pair p of epsilon group g.
package fptd_pkg;

   localparam int NUM_STATES = 8;
   localparam int NUM_EPS    = 4;
   localparam int METRIC_W   = 6;

   typedef logic signed [METRIC_W-1:0] metric_t;
   typedef logic signed [METRIC_W:0]   eps_t;

   localparam logic [2:0] EPS_PAIR [NUM_EPS][4][2] = '{
      '{'{3'd0, 3'd0}, '{3'd1, 3'd4}, '{3'd6, 3'd7}, '{3'd7, 3'd3}},
      '{'{3'd2, 3'd5}, '{3'd3, 3'd1}, '{3'd4, 3'd2}, '{3'd5, 3'd6}},
      '{'{3'd2, 3'd1}, '{3'd3, 3'd5}, '{3'd4, 3'd6}, '{3'd5, 3'd2}},
      '{'{3'd0, 3'd4}, '{3'd1, 3'd0}, '{3'd6, 3'd3}, '{3'd7, 3'd7}}
   };

endpackage

// File: rtl/fptd_epsilon_pipe_lanes_lane.sv
// Per-lane epsilon datapath: 16 alpha+beta sums, then two signed max layers (combinational).
// Layer-1 results leave on l1_o and return on l1_i so the top can cut between them; FPTD_EPS_NORM_EN adds e_k-e1.
module fptd_eps_lane
   import fptd_pkg::*;
#(
   parameter int M = 6
) (
   input  logic [7:1][M-1:0]            alpha_i,
   input  logic [7:1][M-1:0]            beta_i,
   output logic [NUM_EPS-1:0][1:0][M:0] l1_o,
   input  logic [NUM_EPS-1:0][1:0][M:0] l1_i,
   output logic [NUM_EPS-1:0][M:0]      eps_o
);

   logic [M:0] a_x   [NUM_STATES];
   logic [M:0] b_x   [NUM_STATES];
   logic [M:0] sum   [NUM_EPS][4];
   logic [M:0] e_raw [NUM_EPS];

   // Ties may return either operand; returning x keeps it bit-identical either way.
   function automatic logic [M:0] smax(input logic [M:0] x, input logic [M:0] y);
      return ($signed(x) >= $signed(y)) ? x : y;
   endfunction

   always_comb begin
      a_x[0] = '0;
      b_x[0] = '0;
      for (int s = 1; s < NUM_STATES; s++) begin
         a_x[s] = {alpha_i[s][M-1], alpha_i[s]};
         b_x[s] = {beta_i[s][M-1], beta_i[s]};
      end
   end

   always_comb begin
      for (int g = 0; g < NUM_EPS; g++) begin
         for (int p = 0; p < 4; p++) begin
            sum[g][p] = a_x[EPS_PAIR[g][p][0]] + b_x[EPS_PAIR[g][p][1]];
         end
      end
   end

   always_comb begin
      l1_o = '0;
      for (int g = 0; g < NUM_EPS; g++) begin
         l1_o[g][0] = smax(sum[g][0], sum[g][1]);
         l1_o[g][1] = smax(sum[g][2], sum[g][3]);
      end
   end

   always_comb begin
      for (int g = 0; g < NUM_EPS; g++) begin
         e_raw[g] = smax(l1_i[g][0], l1_i[g][1]);
      end
   end

`ifdef FPTD_EPS_NORM_EN
   logic [M+1:0] diff [NUM_EPS];

   // Normalise against e1; saturate on top-two-bit disagreement.
   always_comb begin
      eps_o = '0;
      for (int g = 0; g < NUM_EPS; g++) begin
         diff[g] = {e_raw[g][M], e_raw[g]} - {e_raw[0][M], e_raw[0]};
         if (diff[g][M+1] != diff[g][M]) begin
            eps_o[g] = diff[g][M+1] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
         end else begin
            eps_o[g] = diff[g][M:0];
         end
      end
   end
`else
   always_comb begin
      eps_o = '0;
      for (int g = 0; g < NUM_EPS; g++) begin
         eps_o[g] = e_raw[g];
      end
   end
`endif

endmodule

// File: rtl/fptd_epsilon_pipe_lanes.sv
// FPTD epsilon unit: L lanes behind one valid/ready handshake; FPTD_EPS_NORM_EN selects normalised output.
// Latency D cycles (1 or 2); bubble-collapsing, in_ready = load of the first stage.
// out_valid/data held stable while out_ready=0; flush drops everything in flight and clears the beat counter.
module fptd_epsilon_pipe_lanes
   import fptd_pkg::*;
#(
   parameter int M      = 6,
   parameter int L      = 1,
   parameter int D      = 1,
   parameter int BEAT_W = 12
) (
   input  logic                        Clock,
   input  logic                        nReset,
   input  logic                        flush,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_last,
   input  logic [L-1:0][7:1][M-1:0]    alpha,
   input  logic [L-1:0][7:1][M-1:0]    beta,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic [BEAT_W-1:0]           out_beat,
   output logic [L-1:0][4:1][M:0]      epsilon
);

   logic [L-1:0][NUM_EPS-1:0][1:0][M:0] l1_c;
   logic [L-1:0][NUM_EPS-1:0][1:0][M:0] l1_sel;
   logic [L-1:0][NUM_EPS-1:0][M:0]      eps_c;

   logic                   out_vld_q, out_vld_d, out_last_q;
   logic [L-1:0][4:1][M:0] eps_q;
   logic [BEAT_W-1:0]      beat_q, beat_d;
   logic                   ld_out, src_vld, src_last;

   for (genvar l = 0; l < L; l++) begin : g_lane
      fptd_eps_lane #(.M(M)) u_lane (
         .alpha_i (alpha[l]),
         .beta_i  (beta[l]),
         .l1_o    (l1_c[l]),
         .l1_i    (l1_sel[l]),
         .eps_o   (eps_c[l])
      );
   end

   assign ld_out = !out_vld_q || out_ready;

   if (D == 2) begin : g_mid
      logic                                mid_vld_q, mid_vld_d, mid_last_q, ld_mid;
      logic [L-1:0][NUM_EPS-1:0][1:0][M:0] mid_q;

      assign ld_mid    = !mid_vld_q || ld_out;
      assign mid_vld_d = flush ? 1'b0 : (ld_mid ? in_valid : mid_vld_q);

      always_ff @(posedge Clock or negedge nReset) begin
         if (!nReset) begin
            mid_vld_q  <= 1'b0;
            mid_last_q <= 1'b0;
            mid_q      <= '0;
         end else begin
            mid_vld_q <= mid_vld_d;
            if (ld_mid && in_valid) begin
               mid_last_q <= in_last;
               mid_q      <= l1_c;
            end
         end
      end

      assign in_ready = ld_mid;
      assign src_vld  = mid_vld_q;
      assign src_last = mid_last_q;
      assign l1_sel   = mid_q;
   end else begin : g_flat
      assign in_ready = ld_out;
      assign src_vld  = in_valid;
      assign src_last = in_last;
      assign l1_sel   = l1_c;
   end

   assign out_vld_d = flush ? 1'b0 : (ld_out ? src_vld : out_vld_q);

   // Counter names the beat currently presented; it only moves on an output transfer.
   always_comb begin
      beat_d = beat_q;
      if (flush) begin
         beat_d = '0;
      end else if (out_vld_q && out_ready) begin
         beat_d = out_last_q ? '0 : beat_q + BEAT_W'(1);
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         out_vld_q  <= 1'b0;
         out_last_q <= 1'b0;
         eps_q      <= '0;
         beat_q     <= '0;
      end else begin
         out_vld_q <= out_vld_d;
         beat_q    <= beat_d;
         if (ld_out && src_vld) begin
            out_last_q <= src_last;
            eps_q      <= eps_c;
         end
      end
   end

   assign out_valid = out_vld_q;
   assign out_last  = out_last_q;
   assign out_beat  = beat_q;
   assign epsilon   = eps_q;

endmodule

// File: tb/tb_fptd_epsilon_pipe_lanes.sv
// Scoreboard bench for fptd_epsilon_pipe_lanes (M=6, L=2); D set by parameter, NORM by FPTD_EPS_NORM_EN.
module tb_fptd_epsilon_pipe_lanes;
   parameter int D = 1;
   localparam int M  = 6;
   localparam int L  = 2;
   localparam int BW = 12;

   typedef logic [L-1:0][7:1][M-1:0] met_t;
   typedef logic [L-1:0][4:1][M:0]   epsv_t;
   typedef struct packed {
      epsv_t         eps;
      logic          last;
      logic [BW-1:0] beat;
   } exp_t;

   logic          Clock, nReset, flush, in_valid, in_ready, in_last;
   logic          out_valid, out_ready, out_last;
   met_t          alpha, beta;
   logic [BW-1:0] out_beat;
   epsv_t         epsilon;

   exp_t          q[$];
   int            checks = 0;
   int            errors = 0;
   logic [BW-1:0] exp_beat = '0;
   logic          saw_bp = 1'b0;
   logic          rst_seen = 1'b0;

   fptd_epsilon_pipe_lanes #(.M(M), .L(L), .D(D), .BEAT_W(BW)) dut (
      .Clock(Clock), .nReset(nReset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .alpha(alpha), .beta(beta),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .out_beat(out_beat), .epsilon(epsilon)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic int max4(input int w, input int x, input int y, input int z);
      int m;
      m = w;
      if (x > m) m = x;
      if (y > m) m = y;
      if (z > m) m = z;
      return m;
   endfunction

   // Reference: explicit per-group max of the listed (alpha, beta) pairs.
   function automatic epsv_t model(input met_t av, input met_t bv);
      epsv_t r;
      int a[8];
      int b[8];
      int e[5];
      int d;
      r = '0;
      for (int l = 0; l < L; l++) begin
         a[0] = 0;
         b[0] = 0;
         for (int s = 1; s < 8; s++) begin
            a[s] = int'($signed(av[l][s]));
            b[s] = int'($signed(bv[l][s]));
         end
         e[0] = 0;
         e[1] = max4(a[0]+b[0], a[1]+b[4], a[6]+b[7], a[7]+b[3]);
         e[2] = max4(a[2]+b[5], a[3]+b[1], a[4]+b[2], a[5]+b[6]);
         e[3] = max4(a[2]+b[1], a[3]+b[5], a[4]+b[6], a[5]+b[2]);
         e[4] = max4(a[0]+b[4], a[1]+b[0], a[6]+b[3], a[7]+b[7]);
         for (int k = 1; k <= 4; k++) begin
            d = e[k];
`ifdef FPTD_EPS_NORM_EN
            d = e[k] - e[1];
            if (d > 63) d = 63;
            if (d < -64) d = -64;
`endif
            r[l][k] = 7'(d);
         end
      end
      return r;
   endfunction

   // k=90: all +31, k=91: all -32, otherwise a deterministic spread.
   function automatic met_t pat(input int k, input int sel);
      met_t v;
      for (int l = 0; l < L; l++) begin
         for (int s = 1; s < 8; s++) begin
            if (k == 90)       v[l][s] = 6'd31;
            else if (k == 91)  v[l][s] = 6'(-32);
            else if (sel == 0) v[l][s] = 6'(k*7 + s*5 + l*11 - 20);
            else               v[l][s] = 6'(k*13 - s*3 + l*5);
         end
      end
      return v;
   endfunction

   task automatic send(input met_t av, input met_t bv, input logic last, input epsv_t ex);
      int   n;
      logic rdy;
      @(negedge Clock);
      alpha    = av;
      beta     = bv;
      in_last  = last;
      in_valid = 1'b1;
      n = 0;
      forever begin
         #4;
         rdy = in_ready;
         if (!rdy) saw_bp = 1'b1;
         @(posedge Clock);
         if (rdy) break;
         n++;
         if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept");
            break;
         end
         @(negedge Clock);
      end
      if (rdy) begin
         q.push_back('{eps: ex, last: last, beat: exp_beat});
         exp_beat = last ? '0 : exp_beat + 1'b1;
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge Clock);
         n++;
      end
      @(negedge Clock);
      chk("drain_empty", 80'(q.size()), 80'd0);
   endtask

   // Monitor: pops on every output transfer and checks stall stability.
   initial begin
      logic       prev_stall;
      logic [69:0] snap;
      exp_t       e;
      prev_stall = 1'b0;
      snap = '0;
      forever begin
         @(negedge Clock);
         if (rst_seen) begin
            prev_stall = 1'b0;
            rst_seen   = 1'b0;
         end
         if (prev_stall) chk("stall_hold", 80'({out_valid, out_last, out_beat, epsilon}), 80'(snap));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 80'(epsilon), 80'hdead);
            end else begin
               e = q.pop_front();
               chk("epsilon", 80'(epsilon), 80'(e.eps));
               chk("last_beat", 80'({out_last, out_beat}), 80'({e.last, e.beat}));
            end
         end
         prev_stall = out_valid && !out_ready;
         snap = {out_valid, out_last, out_beat, epsilon};
      end
   end

   initial begin
      met_t  av, bv;
      epsv_t ex;
      int    cyc;
      nReset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      alpha = '0; beta = '0; out_ready = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      chk("rst_out_valid", 80'(out_valid), 80'd0);
      chk("rst_out_last", 80'(out_last), 80'd0);
      chk("rst_out_beat", 80'(out_beat), 80'd0);
      chk("rst_epsilon", 80'(epsilon), 80'd0);
      @(negedge Clock);
      nReset = 1'b1;
      #1 chk("rst_in_ready", 80'(in_ready), 80'd1);

      // Zero metrics: single-beat frame, latency exactly D.
      send('0, '0, 1'b1, '0);
      cyc = 1;
      forever begin
         @(negedge Clock);
         if (out_valid || cyc > 20) break;
         @(posedge Clock);
         cyc++;
      end
      chk("latency", 80'(cyc), 80'(D));
      drain();

      // Lane0 hand vector: a1=5, b4=3, everything else -32.
      av = pat(7, 0);
      bv = pat(7, 1);
      for (int s = 1; s < 8; s++) begin
         av[0][s] = 6'(-32);
         bv[0][s] = 6'(-32);
      end
      av[0][1] = 6'd5;
      bv[0][4] = 6'd3;
      ex = model(av, bv);
`ifdef FPTD_EPS_NORM_EN
      ex[0] = {7'(-3), 7'(-64), 7'(-64), 7'(0)};
`else
      ex[0] = {7'(5), 7'(-64), 7'(-64), 7'(8)};
`endif
      send(av, bv, 1'b0, ex);

      // Five-beat burst with out_ready low for three cycles.
      saw_bp = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               int k;
               k = (i == 3) ? 90 : (i == 4) ? 91 : i + 1;
               send(pat(k, 0), pat(k, 1), 1'b0, model(pat(k, 0), pat(k, 1)));
            end
         end
         begin
            repeat (2) @(posedge Clock);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge Clock);
            #1 out_ready = 1'b1;
         end
      join
      chk("in_ready_backpressure", 80'(saw_bp), 80'd1);
      send(pat(8, 0), pat(8, 1), 1'b1, model(pat(8, 0), pat(8, 1)));
      drain();

      // Two three-beat frames.
      for (int i = 0; i < 6; i++) begin
         send(pat(20 + i, 0), pat(20 + i, 1), (i == 2 || i == 5), model(pat(20 + i, 0), pat(20 + i, 1)));
      end
      drain();

      // Flush with a beat offered: beat dropped, counter cleared.
      send(pat(30, 0), pat(30, 1), 1'b0, model(pat(30, 0), pat(30, 1)));
      drain();
      @(negedge Clock);
      alpha = pat(31, 0); beta = pat(31, 1); in_last = 1'b0;
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge Clock);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      exp_beat = '0;
      chk("flush_out_valid", 80'(out_valid), 80'd0);
      chk("flush_out_beat", 80'(out_beat), 80'd0);
      repeat (3) @(negedge Clock);
      chk("flush_dropped", 80'(out_valid), 80'd0);
      send(pat(32, 0), pat(32, 1), 1'b1, model(pat(32, 0), pat(32, 1)));
      drain();

      // nReset with beats in flight.
      send(pat(40, 0), pat(40, 1), 1'b0, model(pat(40, 0), pat(40, 1)));
      drain();
      @(posedge Clock);
      #1 out_ready = 1'b0;
      @(negedge Clock);
      alpha = pat(41, 0); beta = pat(41, 1); in_last = 1'b0;
      in_valid = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      alpha = pat(42, 0); beta = pat(42, 1);
      @(posedge Clock);
      #1 in_valid = 1'b0;
      @(negedge Clock);
      chk("pre_rst_valid", 80'(out_valid), 80'd1);
      @(posedge Clock);
      #1;
      nReset = 1'b0;
      rst_seen = 1'b1;
      #1;
      chk("midrst_out_valid", 80'(out_valid), 80'd0);
      chk("midrst_epsilon", 80'(epsilon), 80'd0);
      chk("midrst_out_beat", 80'(out_beat), 80'd0);
      q.delete();
      exp_beat = '0;
      #1;
      nReset = 1'b1;
      out_ready = 1'b1;
      send(pat(43, 0), pat(43, 1), 1'b1, model(pat(43, 0), pat(43, 1)));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
